score_text_writer: RTL

- Writer side of the text overlay path: converts a binary score into decimal character codes and writes them into the dual-port character RAM whose read side feeds the on-screen text renderer through 8-bit char_xy addresses.
- Conversion runs immediately on an update request; the RAM writes happen only during vertical blanking, so the displayed number never tears mid-frame.
- Sits between game logic (score source) and the character RAM write port, in the pclk domain.

---
 rtl/score_text_writer.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/score_text_writer.sv
//------------------------------------------------------------------------------
// score_text_writer
//   Converts a binary score to decimal ASCII and writes the digits into the
//   character RAM during vertical blanking, so the on-screen number never
//   tears mid-frame.
//
//   Ports
//     pclk        in   pixel clock
//     rst         in   asynchronous reset, active-low
//     score       in   binary score value (SCORE_W bits)
//     score_valid in   one-cycle update request, score sampled same cycle
//     vblnk_in    in   vertical blanking
//     wr_en       out  character RAM write strobe
//     wr_addr     out  {row[3:0], col[3:0]}
//     wr_data     out  ASCII character code
//     busy        out  high whenever not idle
//     done        out  one-cycle pulse after the last digit is written
//------------------------------------------------------------------------------
`default_nettype none

module score_text_writer #(
    parameter int SCORE_W   = 16,
    parameter int DIGITS    = 5,
    parameter int ROW       = 0,
    parameter int COL_START = 0,
    parameter int LZ_BLANK  = 1
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [SCORE_W-1:0] score,
    input  logic               score_valid,
    input  logic               vblnk_in,
    output logic               wr_en,
    output logic [7:0]         wr_addr,
    output logic [6:0]         wr_data,
    output logic               busy,
    output logic               done
);

    localparam int BCD_W   = 4 * DIGITS;
    localparam int CNT_W   = $clog2(SCORE_W + 1);
    localparam int MAX_VAL = (10 ** DIGITS) - 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CONV    = 3'd1;
    localparam logic [2:0] S_WAIT_VB = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic               seen_nz_q, seen_nz_d;
    logic               pend_q, pend_d;
    logic [SCORE_W-1:0] pend_score_q, pend_score_d;
    logic               wr_en_q, wr_en_d;
    logic [7:0]         wr_addr_q, wr_addr_d;
    logic [6:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // The BCD register is consumed from the top, one digit per write.
    logic [3:0] cur_digit;
    assign cur_digit = bcd_q[BCD_W-1 -: 4];

    // Values that cannot be shown in DIGITS decimal places saturate to all 9s.
    function automatic logic [SCORE_W-1:0] clamp(input logic [SCORE_W-1:0] v);
        if (32'(v) > 32'(MAX_VAL)) begin
            return SCORE_W'(MAX_VAL);
        end
        return v;
    endfunction

    // Double-dabble pre-shift correction: any digit >= 5 gets +3.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            if (r[4*k +: 4] >= 4'd5) begin
                r[4*k +: 4] = r[4*k +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            bin_q        <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            idx_q        <= '0;
            seen_nz_q    <= 1'b0;
            pend_q       <= 1'b0;
            pend_score_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            bcd_q        <= bcd_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            seen_nz_q    <= seen_nz_d;
            pend_q       <= pend_d;
            pend_score_q <= pend_score_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (score_valid) state_d = S_CONV;
            S_CONV:    if (bit_cnt_q == CNT_W'(SCORE_W - 1)) state_d = S_WAIT_VB;
            S_WAIT_VB: if (vblnk_in) state_d = S_WRITE;
            S_WRITE:   if (vblnk_in && (idx_q == 3'(DIGITS - 1))) state_d = S_DONE;
            S_DONE:    state_d = (pend_q || score_valid) ? S_CONV : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath and registered outputs
    //--------------------------------------------------------------------------
    always_comb begin
        bin_d        = bin_q;
        bcd_d        = bcd_q;
        bit_cnt_d    = bit_cnt_q;
        idx_d        = idx_q;
        seen_nz_d    = seen_nz_q;
        pend_d       = pend_q;
        pend_score_d = pend_score_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_q == S_DONE);

        // Requests arriving mid-operation queue up; the newest one wins.
        if (score_valid && (state_q == S_CONV || state_q == S_WAIT_VB ||
                            state_q == S_WRITE)) begin
            pend_d       = 1'b1;
            pend_score_d = score;
        end

        case (state_q)
            S_IDLE: begin
                if (score_valid) begin
                    bin_d     = clamp(score);
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            S_CONV: begin
                bcd_d     = {dd_adjust(bcd_q), bin_q[SCORE_W-1]} [BCD_W-1:0];
                bin_d     = {bin_q[SCORE_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
            S_WAIT_VB: begin
                if (vblnk_in) begin
                    idx_d     = '0;
                    seen_nz_d = 1'b0;
                end
            end
            S_WRITE: begin
                // Outside blanking nothing moves: index and digits hold.
                if (vblnk_in) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = {4'(ROW), 4'(COL_START) + {1'b0, idx_q}};
                    if ((LZ_BLANK != 0) && (cur_digit == 4'd0) && !seen_nz_q &&
                        (idx_q != 3'(DIGITS - 1))) begin
                        wr_data_d = 7'h20;
                    end else begin
                        wr_data_d = 7'h30 + {3'b000, cur_digit};
                    end
                    if (cur_digit != 4'd0) begin
                        seen_nz_d = 1'b1;
                    end
                    bcd_d = bcd_q << 4;
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                // A request in this very cycle is newer than any pending one.
                if (pend_q || score_valid) begin
                    bin_d     = clamp(score_valid ? score : pend_score_q);
                    bcd_d     = '0;
                    bit_cnt_d = '0;
                    pend_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

`default_nettype wire
